// File: rtl/adder_share_pkg.sv
// rtl/adder_share_pkg.sv - shared widths, id sizing and pipeline record types
package adder_share_pkg;

  localparam int DW        = 16;
  localparam int NREQ_DEF  = 4;
  localparam int ID_MAXW   = 3;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // id fields are sized for the largest supported NREQ (8); narrower configs zero-extend
  typedef struct packed {
    logic [DW-1:0]      a;
    logic [DW-1:0]      b;
    logic [ID_MAXW-1:0] id;
  } op_t;

  typedef struct packed {
    logic [DW-1:0]      sum;
    logic               cout;
    logic [ID_MAXW-1:0] id;
  } rsp_t;

endpackage

// File: rtl/cra_adder.sv
// rtl/cra_adder.sv - 16-bit ripple-carry adder datapath
module cra_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic c;

  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < 16; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first request at or after ptr, wrapping
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o
);

  logic         found;
  logic [IDW:0] s;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    s     = '0;
    for (int i = 0; i < NREQ; i++) begin
      s = {1'b0, ptr_i} + (IDW+1)'(i);
      if (s >= (IDW+1)'(NREQ)) s = s - (IDW+1)'(NREQ);
      if (!found && req_i[s[IDW-1:0]]) begin
        found             = 1'b1;
        gnt_o[s[IDW-1:0]] = 1'b1;
        idx_o             = s[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - one cra_adder shared by NREQ requesters, round-robin,
// operand register then result register, one tagged response channel with backpressure
module adder_share_arbiter
  import adder_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IDW = id_width(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic [NREQ-1:0]    req_ready,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DW-1:0]      rsp_sum,
  output logic               rsp_cout,
  output logic [IDW-1:0]     rsp_id
);

  logic            op_valid_q, op_valid_d;
  op_t             op_q, op_d;
  logic            rsp_valid_q, rsp_valid_d;
  rsp_t            rsp_q, rsp_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;

  logic            s1_free, s2_free, xfer;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic [DW-1:0]   a_sel, b_sel, add_sum;
  logic            add_cout;
  logic            unused_id;

  assign s2_free = !rsp_valid_q || rsp_ready;
  assign s1_free = !op_valid_q || s2_free;

  // masking the request vector keeps req_ready all-zero during reset and while S1 is stuck
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i (req_valid & {NREQ{s1_free && !rst}}),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel = req_a[i*DW +: DW];
        b_sel = req_b[i*DW +: DW];
      end
    end
  end

  cra_adder u_add (
    .a    (op_q.a),
    .b    (op_q.b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    op_valid_d  = op_valid_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;

    if (xfer) begin
      rr_ptr_d   = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
      op_valid_d = 1'b1;
      op_d.a     = a_sel;
      op_d.b     = b_sel;
      op_d.id    = ID_MAXW'(gnt_idx);
    end else if (s2_free) begin
      op_valid_d = 1'b0;
    end

    if (s2_free && op_valid_q) begin
      rsp_valid_d = 1'b1;
      rsp_d.sum   = add_sum;
      rsp_d.cout  = add_cout;
      rsp_d.id    = op_q.id;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      op_valid_q  <= 1'b0;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      op_valid_q  <= op_valid_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_q.sum;
  assign rsp_cout  = rsp_q.cout;
  assign rsp_id    = rsp_q.id[IDW-1:0];
  assign unused_id = ^rsp_q.id;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - vector table, hand sequences and scoreboard for adder_share_arbiter
module tb_adder_share_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N*16-1:0] req_a, req_b;
  logic [N-1:0]  req_ready;
  logic          rsp_valid, rsp_ready;
  logic [15:0]   rsp_sum;
  logic          rsp_cout;
  logic [1:0]    rsp_id;

  adder_share_arbiter #(.NREQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] sum; logic cout; logic [1:0] id; } exp_t;
  typedef struct { logic [1:0] id; logic [15:0] a, b, sum; logic cout; } vec_t;

  exp_t        sb[$];
  logic [15:0] va[N], vb[N];
  int          mptr;
  int          passed = 0, total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive packed operands, then observe at the falling edge: grant model, push and pop
  task automatic sample();
    int   g;
    exp_t e;
    logic [16:0] s;
    for (int k = 0; k < N; k++) begin
      req_a[k*16 +: 16] = va[k];
      req_b[k*16 +: 16] = vb[k];
    end
    @(negedge clk);
    if (rst) begin
      mptr = 0;
      chk("reset_ready", req_ready, 0);
    end else begin
      if (req_ready != 0) begin
        g = rr_pick(req_valid, mptr);
        chk("grant", req_ready, (g < 0) ? 0 : (1 << g));
        if (g >= 0) begin
          s = {1'b0, va[g]} + {1'b0, vb[g]};
          sb.push_back('{sum: s[15:0], cout: s[16], id: 2'(g)});
          mptr = (g + 1) % N;
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_rsp", {rsp_cout, rsp_id, rsp_sum}, {e.cout, e.id, e.sum});
        end
      end
    end
  endtask

  vec_t        tbl[6];
  int          nx;
  logic [15:0] held_sum;

  initial begin
    tbl[0] = '{id: 2, a: 16'h1234, b: 16'h0FFF, sum: 16'h2233, cout: 0};
    tbl[1] = '{id: 0, a: 16'hFFFF, b: 16'h0001, sum: 16'h0000, cout: 1};
    tbl[2] = '{id: 1, a: 16'h8000, b: 16'h8000, sum: 16'h0000, cout: 1};
    tbl[3] = '{id: 3, a: 16'h00FF, b: 16'h0F01, sum: 16'h1000, cout: 0};
    tbl[4] = '{id: 3, a: 16'hFFFF, b: 16'hFFFF, sum: 16'hFFFE, cout: 1};
    tbl[5] = '{id: 0, a: 16'h0000, b: 16'h0000, sum: 16'h0000, cout: 0};

    for (int k = 0; k < N; k++) begin va[k] = 16'h0; vb[k] = 16'h0; end
    mptr = 0;
    rst = 1'b1; req_valid = '1; rsp_ready = 1'b0;
    sample(); tick();
    sample(); tick();
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
    sample();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_cout", rsp_cout, 0);
    chk("rst_rsp_id", rsp_id, 0);
    tick();

    for (int t = 0; t < 6; t++) begin
      va[tbl[t].id] = tbl[t].a;
      vb[tbl[t].id] = tbl[t].b;
      req_valid = 4'(1 << tbl[t].id);
      sample();
      chk("vec_ready", req_ready, 1 << tbl[t].id);
      tick();
      req_valid = '0;
      sample();
      chk("vec_lat_low", rsp_valid, 0);
      tick();
      sample();
      chk("vec_lat_high", rsp_valid, 1);
      chk("vec_sum", rsp_sum, tbl[t].sum);
      chk("vec_cout", rsp_cout, tbl[t].cout);
      chk("vec_id", rsp_id, tbl[t].id);
      tick();
    end

    for (int k = 0; k < N; k++) begin va[k] = 16'h1100 * 16'(k + 1); vb[k] = 16'h0F0F + 16'(k); end
    req_valid = '1; rsp_ready = 1'b0; nx = 0; held_sum = '0;
    for (int i = 0; i < 5; i++) begin
      sample();
      if (req_ready != 0) nx++;
      if (i == 2) held_sum = rsp_sum;
      if (i >= 2) begin
        chk("bp_ready_zero", req_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_sum_stable", rsp_sum, held_sum);
      end
      tick();
    end
    chk("bp_in_flight", nx, 2);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin sample(); tick(); end
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin sample(); tick(); end
    chk("bp_drained", sb.size(), 0);

    req_valid = '1; rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin sample(); tick(); end
    rst = 1'b1;
    sample(); tick();
    rst = 1'b0;
    sb.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      sample();
      chk("fair_grant", req_ready, 1 << (i % 4));
      if (i == 0) chk("post_rst_rsp_valid", rsp_valid, 0);
      if (i >= 2) chk("fair_rsp_valid", rsp_valid, 1);
      tick();
      for (int k = 0; k < N; k++) begin va[k] = 16'($urandom); vb[k] = 16'($urandom); end
    end
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin sample(); tick(); end
    chk("fair_drained", sb.size(), 0);

    for (int i = 0; i < 10000; i++) begin
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(3) != 0);
      for (int k = 0; k < N; k++) begin va[k] = 16'($urandom); vb[k] = 16'($urandom); end
      sample();
      tick();
    end
    req_valid = '0; rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin sample(); tick(); end
    chk("rand_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
